// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage Y86-64 core: per-cycle stall/bubble
// controls, run-state FSM, and saturating cycle / retired-instruction counters.
module pipe_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [1:0]       m_stat,
    input  logic [3:0]       W_icode,
    input  logic [1:0]       W_stat,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic [1:0]       run_state,
    output logic [1:0]       cpu_stat,
    output logic             done,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instr_cnt
);

    // state | meaning
    // IDLE  | waiting for start; pipe drains to nops, PC frozen
    // RUN   | normal execution, hazard logic active
    // HALT  | halt retired; everything frozen until rst
    // ERR   | ADR/INS exception retired; frozen until rst
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10,
        ST_ERR  = 2'b11
    } state_t;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;

    state_t state_q, state_d;

    logic lu, ret, mp, exc;
    logic d_bubble_raw;

    always_comb begin
        lu  = (E_icode == I_MRMOVQ || E_icode == I_POPQ) && (E_dstM != R_NONE) &&
              (E_dstM == d_srcA || E_dstM == d_srcB);
        ret = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
        mp  = (E_icode == I_JXX) && !e_Cnd;
        exc = (m_stat != 2'b00) || (W_stat != 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        F_stall      = 1'b0;
        D_stall      = 1'b0;
        d_bubble_raw = 1'b0;
        E_bubble     = 1'b0;
        M_bubble     = 1'b0;
        W_stall      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                F_stall      = 1'b1;
                d_bubble_raw = 1'b1;
                E_bubble     = 1'b1;
                M_bubble     = 1'b1;
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                F_stall      = lu | ret;
                D_stall      = lu;
                d_bubble_raw = mp | (ret & !lu);
                E_bubble     = mp | lu;
                M_bubble     = exc;
                W_stall      = (W_stat != 2'b00);
                if (W_stat == 2'b01)      state_d = ST_HALT;
                else if (W_stat[1])       state_d = ST_ERR;
            end
            default: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                M_bubble = 1'b1;
                W_stall  = 1'b1;
            end
        endcase
        // A stalled decode register must keep its contents, so stall wins.
        D_bubble = d_bubble_raw & !D_stall;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_stat  <= 2'b00;
            cycle_cnt <= '0;
            instr_cnt <= '0;
        end else if (state_q == ST_RUN) begin
            if (state_d != ST_RUN) cpu_stat <= W_stat;
            if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (W_stat == 2'b00 && W_icode != I_NOP && instr_cnt != '1)
                instr_cnt <= instr_cnt + CNT_W'(1);
        end
    end

    assign run_state = state_q;
    assign done      = (state_q == ST_HALT) || (state_q == ST_ERR);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: hazard controls, run-state FSM, counters and
// saturation (a second instance with CNT_W=4 shares all inputs).
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, e_Cnd;
    logic [3:0]  D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode, W_icode;
    logic [1:0]  m_stat, W_stat;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, done;
    logic [1:0]  run_state, cpu_stat;
    logic [31:0] cycle_cnt, instr_cnt;
    logic        s_F_stall, s_D_stall, s_D_bubble, s_E_bubble, s_M_bubble, s_W_stall, s_done;
    logic [1:0]  s_run_state, s_cpu_stat;
    logic [3:0]  s_cycle_cnt, s_instr_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_bubble(M_bubble), .W_stall(W_stall),
        .run_state(run_state), .cpu_stat(cpu_stat), .done(done),
        .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
    );

    pipe_ctrl #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .start(start),
        .D_icode(D_icode), .d_srcA(d_srcA), .d_srcB(d_srcB),
        .E_icode(E_icode), .E_dstM(E_dstM), .e_Cnd(e_Cnd),
        .M_icode(M_icode), .m_stat(m_stat), .W_icode(W_icode), .W_stat(W_stat),
        .F_stall(s_F_stall), .D_stall(s_D_stall), .D_bubble(s_D_bubble),
        .E_bubble(s_E_bubble), .M_bubble(s_M_bubble), .W_stall(s_W_stall),
        .run_state(s_run_state), .cpu_stat(s_cpu_stat), .done(s_done),
        .cycle_cnt(s_cycle_cnt), .instr_cnt(s_instr_cnt)
    );

    // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall}
    wire [5:0] ctl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall};

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        start = 1'b0; e_Cnd = 1'b1;
        D_icode = 4'h1; E_icode = 4'h1; M_icode = 4'h1; W_icode = 4'h1;
        d_srcA = 4'hF; d_srcB = 4'hF; E_dstM = 4'hF;
        m_stat = 2'b00; W_stat = 2'b00;
    endtask

    task automatic reset_and_start();
        idle_inputs();
        rst = 1'b1; tick(1);
        rst = 1'b0; start = 1'b1; tick(1);
        start = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1; tick(1);
        rst = 1'b0; tick(4);
        tests++;
        if (run_state !== 2'b00 || done !== 1'b0 || cpu_stat !== 2'b00) begin
            fails++;
            $display("FAIL reset_state: run_state=%b done=%b cpu_stat=%b, want 00/0/00", run_state, done, cpu_stat);
        end
        tests++;
        if (ctl !== 6'b101110) begin
            fails++;
            $display("FAIL reset_ctl: got %b want 101110", ctl);
        end
        tests++;
        if (cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            fails++;
            $display("FAIL reset_cnt: cycle=%0d instr=%0d want 0/0", cycle_cnt, instr_cnt);
        end
        start = 1'b1; tick(1); start = 1'b0;
        tests++;
        if (run_state !== 2'b01) begin
            fails++;
            $display("FAIL start_run: run_state=%b want 01", run_state);
        end
        #1;
        tests++;
        if (ctl !== 6'b000000) begin
            fails++;
            $display("FAIL run_quiet: got %b want 000000", ctl);
        end
    endtask

    task automatic test_load_use();
        E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3; #1;
        tests++;
        if (ctl !== 6'b110100) begin
            fails++;
            $display("FAIL load_use_srcA: got %b want 110100", ctl);
        end
        E_dstM = 4'hF; d_srcA = 4'hF; #1;
        tests++;
        if (ctl !== 6'b000000) begin
            fails++;
            $display("FAIL load_use_none: got %b want 000000", ctl);
        end
        E_icode = 4'hB; E_dstM = 4'h4; d_srcB = 4'h4; #1;
        tests++;
        if (ctl !== 6'b110100) begin
            fails++;
            $display("FAIL load_use_popq_srcB: got %b want 110100", ctl);
        end
        E_icode = 4'h2; #1;
        tests++;
        if (ctl !== 6'b000000) begin
            fails++;
            $display("FAIL load_use_not_load: got %b want 000000", ctl);
        end
        // load/use together with a ret in decode: stall, no decode bubble
        E_icode = 4'h5; D_icode = 4'h9; #1;
        tests++;
        if (ctl !== 6'b110100) begin
            fails++;
            $display("FAIL load_use_plus_ret: got %b want 110100", ctl);
        end
        idle_inputs(); #1;
    endtask

    task automatic test_mispredict();
        E_icode = 4'h7; e_Cnd = 1'b0; #1;
        tests++;
        if (ctl !== 6'b001100) begin
            fails++;
            $display("FAIL mispredict: got %b want 001100", ctl);
        end
        e_Cnd = 1'b1; #1;
        tests++;
        if (ctl !== 6'b000000) begin
            fails++;
            $display("FAIL predicted_taken: got %b want 000000", ctl);
        end
        idle_inputs(); #1;
    endtask

    task automatic test_ret();
        logic [3:0] walk [4] = '{4'h9, 4'h1, 4'h1, 4'h1};
        for (int s = 0; s < 4; s++) begin
            D_icode = (s == 0) ? 4'h9 : 4'h1;
            E_icode = (s == 1) ? 4'h9 : 4'h1;
            M_icode = (s == 2) ? 4'h9 : 4'h1;
            W_icode = (s == 3) ? 4'h9 : walk[s];
            #1;
            tests++;
            if (s < 3 && ctl !== 6'b101000) begin
                fails++;
                $display("FAIL ret_stage%0d: got %b want 101000", s, ctl);
            end else if (s == 3 && ctl !== 6'b000000) begin
                fails++;
                $display("FAIL ret_in_W: got %b want 000000", ctl);
            end
            tick(1);
        end
        idle_inputs();
        m_stat = 2'b10; #1;
        tests++;
        if (ctl !== 6'b000010) begin
            fails++;
            $display("FAIL mem_exception: got %b want 000010", ctl);
        end
        idle_inputs(); #1;
    endtask

    task automatic test_program_halt();
        reset_and_start();
        W_icode = 4'h3; tick(3);
        W_icode = 4'h0; W_stat = 2'b01; #1;
        tests++;
        if (ctl !== 6'b000011) begin
            fails++;
            $display("FAIL halt_in_W_ctl: got %b want 000011", ctl);
        end
        tick(1);
        tests++;
        if (run_state !== 2'b10 || cpu_stat !== 2'b01 || done !== 1'b1) begin
            fails++;
            $display("FAIL halt_state: run_state=%b cpu_stat=%b done=%b want 10/01/1", run_state, cpu_stat, done);
        end
        tests++;
        if (instr_cnt !== 32'd3 || cycle_cnt !== 32'd4) begin
            fails++;
            $display("FAIL halt_counts: instr=%0d cycle=%0d want 3/4", instr_cnt, cycle_cnt);
        end
        W_stat = 2'b00; W_icode = 4'h3; start = 1'b1; E_icode = 4'h7; e_Cnd = 1'b0;
        tick(3);
        tests++;
        if (run_state !== 2'b10 || ctl !== 6'b110011 || instr_cnt !== 32'd3 || cycle_cnt !== 32'd4) begin
            fails++;
            $display("FAIL halt_frozen: state=%b ctl=%b instr=%0d cycle=%0d want 10/110011/3/4", run_state, ctl, instr_cnt, cycle_cnt);
        end
        idle_inputs();
        rst = 1'b1; tick(1); rst = 1'b0;
        tests++;
        if (run_state !== 2'b00 || cycle_cnt !== 32'd0 || instr_cnt !== 32'd0 || cpu_stat !== 2'b00 || done !== 1'b0) begin
            fails++;
            $display("FAIL rst_from_halt: state=%b cycle=%0d instr=%0d cpu_stat=%b done=%b", run_state, cycle_cnt, instr_cnt, cpu_stat, done);
        end
    endtask

    task automatic test_program_err();
        reset_and_start();
        W_icode = 4'h3; tick(2);
        W_stat = 2'b11; tick(1);
        tests++;
        if (run_state !== 2'b11 || cpu_stat !== 2'b11 || done !== 1'b1) begin
            fails++;
            $display("FAIL err_state: run_state=%b cpu_stat=%b done=%b want 11/11/1", run_state, cpu_stat, done);
        end
        tests++;
        if (instr_cnt !== 32'd2 || cycle_cnt !== 32'd3) begin
            fails++;
            $display("FAIL err_counts: instr=%0d cycle=%0d want 2/3", instr_cnt, cycle_cnt);
        end
        W_stat = 2'b10; tick(1);
        tests++;
        if (run_state !== 2'b11 || cpu_stat !== 2'b11) begin
            fails++;
            $display("FAIL err_terminal: run_state=%b cpu_stat=%b want 11/11", run_state, cpu_stat);
        end
        idle_inputs();
    endtask

    task automatic test_rst_midrun();
        reset_and_start();
        tick(40);
        tests++;
        if (cycle_cnt !== 32'd40 || instr_cnt !== 32'd0 || run_state !== 2'b01) begin
            fails++;
            $display("FAIL nop_run_40: cycle=%0d instr=%0d state=%b want 40/0/01", cycle_cnt, instr_cnt, run_state);
        end
        rst = 1'b1; start = 1'b1; tick(1); rst = 1'b0; start = 1'b0;
        tests++;
        if (run_state !== 2'b00 || cycle_cnt !== 32'd0 || instr_cnt !== 32'd0) begin
            fails++;
            $display("FAIL rst_midrun: state=%b cycle=%0d instr=%0d want 00/0/0", run_state, cycle_cnt, instr_cnt);
        end
    endtask

    task automatic test_saturate();
        reset_and_start();
        W_icode = 4'h3; tick(20);
        tests++;
        if (s_cycle_cnt !== 4'd15 || s_instr_cnt !== 4'd15) begin
            fails++;
            $display("FAIL sat_cnt4: cycle=%0d instr=%0d want 15/15", s_cycle_cnt, s_instr_cnt);
        end
        tests++;
        if (cycle_cnt !== 32'd20 || instr_cnt !== 32'd20) begin
            fails++;
            $display("FAIL cnt32_20: cycle=%0d instr=%0d want 20/20", cycle_cnt, instr_cnt);
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_load_use();
        test_mispredict();
        test_ret();
        test_program_halt();
        test_program_err();
        test_rst_midrun();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
